// File: rtl/universal_result_collector_if.sv
// universal_result_collector_if: systolic result stream in, requantised FIFO drain out.
interface universal_result_collector_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int COUNT_WIDTH  = 8
);
    logic [RESULT_WIDTH:0]           input_result;
    logic                            output_ready;
    logic [DATA_WIDTH-1:0]           output_value;
    logic                            output_valid;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;
    logic [COUNT_WIDTH-1:0]          result_counter;
    logic                            layer_done;
    logic                            overflow;
    modport master (
        output input_result, output_ready,
        input  output_value, output_valid, fifo_count, result_counter, layer_done, overflow
    );
    modport slave (
        input  input_result, output_ready,
        output output_value, output_valid, fifo_count, result_counter, layer_done, overflow
    );
endinterface

// File: rtl/universal_result_collector.sv
// universal_result_collector: requantise the chain's valid results, buffer them and drain via valid/ready.
module universal_result_collector #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int SHIFT        = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int RESULT_COUNT = 8,
    parameter int COUNT_WIDTH  = 8
) (
    input logic clk,
    input logic reset_n,
    input logic clear,
    universal_result_collector_if.slave bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXV = (1 << DATA_WIDTH) - 1;

    logic                    stage_valid;
    logic [DATA_WIDTH-1:0]   stage_data;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic [COUNT_WIDTH-1:0]  res_cnt;
    logic                    ovf;
    logic [RESULT_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]   sat_val;
    logic                    full, pop, push;

    assign shifted = bus.input_result[RESULT_WIDTH-1:0] >> SHIFT;
    assign sat_val = (shifted > RESULT_WIDTH'(MAXV)) ? '1 : shifted[DATA_WIDTH-1:0];
    assign full    = count == CW'(FIFO_DEPTH);
    assign pop     = bus.output_valid && bus.output_ready;
    // A full FIFO still accepts the staged result when the head leaves on the same edge.
    assign push    = stage_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            res_cnt     <= '0;
            ovf         <= 1'b0;
        end else begin
            stage_valid <= bus.input_result[RESULT_WIDTH];
            stage_data  <= sat_val;
            if (clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                res_cnt <= '0;
                ovf     <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop) count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
                if (stage_valid && !push) ovf <= 1'b1;
                if (stage_valid && res_cnt != COUNT_WIDTH'(RESULT_COUNT)) res_cnt <= res_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && !clear && push) mem[wr_ptr] <= stage_data;
    end

    // Storage is not reset, so the head is masked to zero while the FIFO is empty.
    assign bus.output_valid   = count != '0;
    assign bus.output_value   = bus.output_valid ? mem[rd_ptr] : '0;
    assign bus.fifo_count     = count;
    assign bus.result_counter = res_cnt;
    assign bus.layer_done     = res_cnt == COUNT_WIDTH'(RESULT_COUNT);
    assign bus.overflow       = ovf;
endmodule

// File: tb/tb_universal_result_collector.sv
// tb_universal_result_collector: randomized and directed stimulus checked against a queue-based model.
module tb_universal_result_collector;
    localparam int DW = 8, RW = 16, SH = 2, DEPTH = 8, RC = 8, CWD = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   en = 1'b0;

    int   q[$];
    int   got[$];
    bit   m_pv = 1'b0;
    int   m_pd = 0;
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;

    universal_result_collector_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CWD)) bus();

    universal_result_collector #(
        .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .SHIFT(SH),
        .FIFO_DEPTH(DEPTH), .RESULT_COUNT(RC), .COUNT_WIDTH(CWD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clear(clear),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int sat(int x);
        int s;
        s = x / (1 << SH);
        return (s > (1 << DW) - 1) ? (1 << DW) - 1 : s;
    endfunction

    task automatic chk(string n, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // The model holds the one result sampled last edge, then the FIFO contents as a plain queue.
    task automatic model_update(bit v, int d, bit rdy, bit clr, bit rn);
        if (!rn) begin
            q.delete();
            m_pv = 1'b0;
            m_cnt = 0;
            m_ovf = 1'b0;
            return;
        end
        if (clr) begin
            q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (m_pv) begin
                if (m_cnt < RC) m_cnt++;
                if (q.size() < DEPTH) q.push_back(m_pd);
                else m_ovf = 1'b1;
            end
        end
        m_pv = v;
        m_pd = sat(d);
    endtask

    task automatic tick(bit v, int d, bit rdy, bit clr = 1'b0, bit rn = 1'b1);
        bus.input_result = {v, RW'(d)};
        bus.output_ready = rdy;
        clear = clr;
        reset_n = rn;
        @(posedge clk);
        model_update(v, d, rdy, clr, rn);
        #1;
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("fifo_count", int'(bus.fifo_count), q.size());
            chk("output_valid", int'(bus.output_valid), int'(q.size() > 0));
            if (q.size() > 0) chk("output_value", int'(bus.output_value), q[0]);
            chk("result_counter", int'(bus.result_counter), m_cnt);
            chk("layer_done", int'(bus.layer_done), int'(m_cnt == RC));
            chk("overflow", int'(bus.overflow), int'(m_ovf));
            if (bus.output_valid && bus.output_ready) got.push_back(int'(bus.output_value));
        end
    end

    initial begin
        bus.input_result = '0;
        bus.output_ready = 1'b0;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        en = 1'b1;
        chk("rst_valid", int'(bus.output_valid), 0);
        chk("rst_value", int'(bus.output_value), 0);
        chk("rst_count", int'(bus.fifo_count), 0);
        chk("rst_done", int'(bus.layer_done), 0);

        tick(1, 8, 0);
        tick(1, 12, 0);
        tick(1, 16, 0);
        tick(0, 0, 0);
        chk("pre_reset_count", int'(bus.fifo_count), 3);
        tick(0, 0, 0, 0, 0);
        chk("midrst_count", int'(bus.fifo_count), 0);
        chk("midrst_valid", int'(bus.output_valid), 0);
        chk("midrst_counter", int'(bus.result_counter), 0);
        chk("midrst_overflow", int'(bus.overflow), 0);

        got.delete();
        tick(1, 13, 1);
        chk("lat_e0_valid", int'(bus.output_valid), 0);
        tick(1, 55, 1);
        chk("lat_e1_valid", int'(bus.output_valid), 1);
        chk("lat_e1_value", int'(bus.output_value), 3);
        tick(1, 1023, 1);
        tick(1, 1024, 1);
        tick(0, 500, 1);
        tick(0, 0, 1);
        tick(0, 0, 1);
        chk("rq_len", got.size(), 4);
        if (got.size() == 4) begin
            chk("rq_0", got[0], 3);
            chk("rq_1", got[1], 13);
            chk("rq_2", got[2], 255);
            chk("rq_3", got[3], 255);
        end
        chk("rq_counter", int'(bus.result_counter), 4);

        tick(0, 0, 0, 1);
        for (int k = 1; k <= 9; k++) tick(1, 4 * k, 0);
        tick(0, 0, 0);
        chk("bp_count", int'(bus.fifo_count), 8);
        chk("bp_overflow", int'(bus.overflow), 1);
        chk("bp_counter", int'(bus.result_counter), 8);
        chk("bp_done", int'(bus.layer_done), 1);
        got.delete();
        repeat (10) tick(0, 0, 1);
        chk("bp_drain_len", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_drain_val", got[i], i + 1);
        chk("bp_empty", int'(bus.output_valid), 0);

        tick(1, 100, 0);
        tick(1, 100, 0);
        tick(0, 0, 0);
        tick(0, 0, 0, 1);
        chk("clr_done", int'(bus.layer_done), 0);
        chk("clr_overflow", int'(bus.overflow), 0);
        chk("clr_count", int'(bus.fifo_count), 0);
        chk("clr_valid", int'(bus.output_valid), 0);
        chk("clr_counter", int'(bus.result_counter), 0);

        for (int k = 1; k <= 8; k++) tick(1, 4 * k, 0);
        tick(0, 0, 0);
        chk("pp_full", int'(bus.fifo_count), 8);
        tick(1, 40, 0);
        got.delete();
        tick(0, 0, 1);
        chk("pp_count", int'(bus.fifo_count), 8);
        chk("pp_overflow", int'(bus.overflow), 0);
        repeat (10) tick(0, 0, 1);
        chk("pp_len", got.size(), 9);
        if (got.size() == 9) begin
            chk("pp_first", got[0], 1);
            chk("pp_last", got[8], 10);
        end

        tick(0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            tick(i % 5 < 2, int'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1);
        tick(0, 0, 1);
        tick(0, 0, 1);
        chk("ld_done", int'(bus.layer_done), 1);
        chk("ld_counter", int'(bus.result_counter), 8);
        tick(1, 77, 1);
        tick(0, 0, 1);
        tick(0, 0, 1);
        chk("ld_sat_counter", int'(bus.result_counter), 8);

        repeat (600) begin
            tick($urandom_range(0, 9) < 7,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1200)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 149) != 0);
        end
        repeat (12) tick(0, 0, 1);
        chk("end_empty", int'(bus.output_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/universal_result_collector.md
Name: universal_result_collector

Overview:
- Downstream neighbour of the last weight computation cell in a systolic chain.
- Samples the chain's `{valid, result}` stream and requantises each valid result (right shift, then unsigned saturation) to DATA_WIDTH.
- Buffers requantised values in a FIFO and drains them through a valid/ready handshake towards the next layer's input feeder.
- Counts results per layer and flags layer completion and FIFO overflow.

Parameters:
- DATA_WIDTH, 8, width of each requantised output value.
- RESULT_WIDTH, 16, width of the result payload; input is RESULT_WIDTH+1 bits, MSB = valid.
- SHIFT, 2, right-shift amount applied before saturation.
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2.
- RESULT_COUNT, 8, valid results per layer.
- COUNT_WIDTH, 8, width of result_counter; must hold RESULT_COUNT.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous layer clear: flushes FIFO, zeroes counter, clears flags.
- input_result  in  RESULT_WIDTH+1  bit RESULT_WIDTH = valid, lower bits = unsigned result.
- output_ready  in  1  consumer accepts the head entry this cycle.
- output_value  out  DATA_WIDTH  FIFO head value.
- output_valid  out  1  FIFO not empty.
- fifo_count  out  log2(FIFO_DEPTH)+1  occupied entries.
- result_counter  out  COUNT_WIDTH  valid results captured this layer, including dropped ones.
- layer_done  out  1  level; result_counter == RESULT_COUNT.
- overflow  out  1  sticky; at least one result dropped.

Behaviour:
- Reset: when reset_n = 0 at a rising edge, clear all state.
  - Outputs after reset: output_valid=0, output_value=0, fifo_count=0, result_counter=0, layer_done=0, overflow=0.
  - Internal state after reset: stage register valid bit = 0, FIFO pointers = 0.
  - Reset has priority over clear and over all other activity.
- Stage 1 (requantise register), on every edge:
  - stage_valid <= input_result[RESULT_WIDTH].
  - stage_data <= sat(input_result[RESULT_WIDTH-1:0] >> SHIFT).
  - sat(x) = (x > 2^DATA_WIDTH−1) ? 2^DATA_WIDTH−1 : x.
  - Logical shift; the payload is unsigned.
- Results with valid bit 0 are ignored entirely and the counter does not move. Back-to-back valid results are accepted every cycle.
- Stage 2 (FIFO write):
  - When stage_valid=1, push stage_data on the next edge unless the FIFO is full and no pop occurs on that edge.
  - push = stage_valid && (!full || pop), where pop = output_valid && output_ready.
- Full with simultaneous pop: push and pop both occur, fifo_count is unchanged, and the write pointer takes the freed slot.
- Full with no pop: the result is dropped and overflow is set (sticky until clear or reset).
- Pop on an empty FIFO is impossible, because output_valid=0 when empty.
- Output path:
  - output_value is the head entry, read combinationally from FIFO storage indexed by the read pointer.
  - output_value holds its value while output_valid=1 and output_ready=0.
- Latency: a valid result sampled at edge E0 reaches output_valid=1 after edge E1 (2 edges) when the FIFO is not full.
- Pointers: wrap modulo FIFO_DEPTH. fifo_count goes +1 on push only, −1 on pop only, and is unchanged when push and pop coincide.
- result_counter:
  - Increments on each stage_valid=1 edge, whether the result is pushed or dropped.
  - Saturates at RESULT_COUNT; further valid results are still pushed but not counted.
  - layer_done = (result_counter == RESULT_COUNT), registered-derived, with no combinational path from the input.
- clear (edge with reset_n=1, clear=1):
  - Zeroes both pointers, fifo_count, result_counter and overflow; layer_done therefore drops.
  - A stage_valid entry present on the same edge is discarded.
  - An input sampled on the same edge is still captured into the stage register and counts in the new layer.

Test Plan:
- Reset mid-stream: push 3 values with output_ready=0, then assert reset_n=0 for one edge → fifo_count=0, output_valid=0, result_counter=0, overflow=0.
- Requantisation (SHIFT=2), output_ready=1: inputs {1,13},{1,55},{1,1023},{1,1024},{0,500} on consecutive cycles → outputs 3, 13, 255, 255 on consecutive cycles, first one 2 edges after the first input; 500 never appears; result_counter=4.
- Backpressure and full: output_ready=0, 9 consecutive valid inputs {1,4·k} for k=1..9 → fifo_count=8, overflow=1 after the 9th reaches stage 2. Then output_ready=1 → values 1..8 in order, then output_valid=0.
- Simultaneous push/pop when full: fill to 8 entries, then one valid input {1,40} while output_ready=1 on the same edge → fifo_count stays 8, overflow=0; drain order ends with 10.
- Layer completion: 8 valid inputs spread over 20 cycles with random output_ready → layer_done=1 after the 8th is registered; a 9th valid input is pushed and result_counter stays 8.
- Clear: a clear pulse with layer_done=1 and overflow=1 → next cycle layer_done=0, overflow=0, fifo_count=0, output_valid=0.
